v2f_divmod_iter: RTL and testbench

Iterative signed/unsigned integer divider producing quotient and remainder together, with Factorio combinator semantics. It is the sequential implementation behind the `v2f_div` and `v2f_mod` cells emitted by the techmap stage, for simulation and for flows that want one shared multi-cycle divider. It replaces a pair of single-tick combinators. Operands enter through a valid/ready handshake; results leave through a second valid/ready handshake.

---
 rtl/v2f_pkg.sv | 24 ++
 rtl/v2f_divmod_step.sv | 27 ++
 rtl/v2f_divmod_iter.sv | 156 +++++++++++++++
 tb/tb_v2f_divmod_iter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/v2f_pkg.sv
// Shared definitions for the v2f divider: FSM state type, width limit and
// a two's-complement magnitude helper.
package v2f_pkg;

  localparam int V2F_MAX_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } v2f_divmod_state_t;

  // Magnitude of a sign-extended value. The result is one bit wider than
  // V2F_MAX_WIDTH so |MIN| is represented exactly.
  function automatic logic [V2F_MAX_WIDTH:0] v2f_mag(input logic [V2F_MAX_WIDTH:0] x);
    if (x[V2F_MAX_WIDTH])
      return ~x + {{V2F_MAX_WIDTH{1'b0}}, 1'b1};
    else
      return x;
  endfunction

endpackage

// File: rtl/v2f_divmod_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module v2f_divmod_step
  import v2f_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-2:0] quo,
  input  logic [WIDTH:0]   div,
  input  logic             dbit,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             ge;

  // The compare uses one extra bit so no shifted-out remainder bit is lost.
  assign shifted  = {rem, dbit};
  assign ge       = (shifted >= {1'b0, div});
  assign diff     = shifted[WIDTH:0] - div;
  assign rem_next = ge ? diff : shifted[WIDTH:0];
  assign quo_next = {quo, ge};

endmodule

// File: rtl/v2f_divmod_iter.sv
// Iterative signed/unsigned divider with combinator semantics (x/0 = 0,
// x%0 = 0, MIN/-1 wraps). Quotient truncates toward zero, remainder takes
// the sign of the dividend.
// Optional build macro V2F_DIVMOD_EARLY_TERM_EN: skip the leading zero bits
// of |a| so latency tracks the dividend's significant bits.
module v2f_divmod_iter
  import v2f_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  // Counter indexes the WIDTH+1-bit dividend register.
  localparam int CW = $clog2(WIDTH + 1);

  v2f_divmod_state_t state_reg;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH:0]   dvd_reg, dvs_reg, racc_reg;
  logic [WIDTH-1:0] qacc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             sign_q_reg, sign_r_reg, bzero_reg;
  logic [WIDTH-1:0] quo_reg, rem_reg;
  logic             dbz_reg;

  logic [V2F_MAX_WIDTH:0] a_ext, b_ext, a_abs, b_abs;
  logic [WIDTH:0]         step_rem;
  logic [WIDTH-1:0]       step_quo;
  logic                   b_is_zero;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign quo       = quo_reg;
  assign rem       = rem_reg;
  assign dbz       = dbz_reg;
  assign b_is_zero = (b_reg == '0);

  // Extend the latched operands (sign or zero) and take their magnitudes.
  always_comb begin
    a_ext = {(V2F_MAX_WIDTH + 1){SIGNED & a_reg[WIDTH-1]}};
    b_ext = {(V2F_MAX_WIDTH + 1){SIGNED & b_reg[WIDTH-1]}};
    a_ext[WIDTH-1:0] = a_reg;
    b_ext[WIDTH-1:0] = b_reg;
    a_abs = v2f_mag(a_ext);
    b_abs = v2f_mag(b_ext);
  end

`ifdef V2F_DIVMOD_EARLY_TERM_EN
  logic [CW-1:0] a_msb;
  logic          a_nz;

  assign a_nz = |a_abs[WIDTH:0];

  // Index of the highest set bit of |a|; iteration starts there.
  always_comb begin
    a_msb = '0;
    for (int i = 0; i < WIDTH; i++)
      if (a_abs[i]) a_msb = CW'(i);
  end
`endif

  v2f_divmod_step #(.WIDTH(WIDTH)) u_step (
    .rem      (racc_reg),
    .quo      (qacc_reg[WIDTH-2:0]),
    .div      (dvs_reg),
    .dbit     (dvd_reg[cnt_reg]),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      racc_reg   <= '0;
      qacc_reg   <= '0;
      cnt_reg    <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      bzero_reg  <= 1'b0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      dbz_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            state_reg <= PREP;
          end
        end
        PREP: begin
          dvd_reg    <= a_abs[WIDTH:0];
          dvs_reg    <= b_abs[WIDTH:0];
          sign_q_reg <= SIGNED & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          sign_r_reg <= SIGNED & a_reg[WIDTH-1];
          bzero_reg  <= b_is_zero;
          racc_reg   <= '0;
          qacc_reg   <= '0;
`ifdef V2F_DIVMOD_EARLY_TERM_EN
          cnt_reg    <= a_msb;
          state_reg  <= (b_is_zero || !a_nz) ? FIX : ITER;
`else
          cnt_reg    <= CW'(WIDTH - 1);
          state_reg  <= b_is_zero ? FIX : ITER;
`endif
        end
        ITER: begin
          racc_reg <= step_rem;
          qacc_reg <= step_quo;
          if (cnt_reg == '0)
            state_reg <= FIX;
          else
            cnt_reg <= cnt_reg - 1'b1;
        end
        FIX: begin
          if (bzero_reg) begin
            quo_reg <= '0;
            rem_reg <= '0;
          end else begin
            quo_reg <= sign_q_reg ? ({WIDTH{1'b0}} - qacc_reg) : qacc_reg;
            rem_reg <= sign_r_reg ? ({WIDTH{1'b0}} - racc_reg[WIDTH-1:0])
                                  : racc_reg[WIDTH-1:0];
          end
          dbz_reg   <= bzero_reg;
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            dbz_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v2f_divmod_iter.sv
// Directed testbench for v2f_divmod_iter: one signed and one unsigned
// instance, hand-computed quotient/remainder/latency per vector.
module tb_v2f_divmod_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        iv_s = 1'b0, iv_u = 1'b0, out_ready = 1'b0;
  logic        use_u = 1'b0;

  logic        ir_s, ov_s, dbz_s, ir_u, ov_u, dbz_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        ir, ov, dbz_o;
  logic [31:0] quo_o, rem_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  v2f_divmod_iter #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s), .a(a), .b(b),
    .out_valid(ov_s), .out_ready(out_ready), .quo(quo_s), .rem(rem_s), .dbz(dbz_s)
  );

  v2f_divmod_iter #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_u), .in_ready(ir_u), .a(a), .b(b),
    .out_valid(ov_u), .out_ready(out_ready), .quo(quo_u), .rem(rem_u), .dbz(dbz_u)
  );

  assign ir    = use_u ? ir_u  : ir_s;
  assign ov    = use_u ? ov_u  : ov_s;
  assign dbz_o = use_u ? dbz_u : dbz_s;
  assign quo_o = use_u ? quo_u : quo_s;
  assign rem_o = use_u ? rem_u : rem_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected accept-to-valid latency, counting the accepting edge as 1.
  function automatic int exp_lat(input bit u, input logic [31:0] av, input logic [31:0] bv);
`ifdef V2F_DIVMOD_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    if (bv == 32'd0) return 3;
    m = (!u && av[31]) ? (32'd0 - av) : av;
    n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return 3 + n;
`else
    return (bv == 32'd0) ? 3 : 35;
`endif
  endfunction

  // Called at a negedge; returns at a negedge after the output handshake.
  task automatic do_op(input bit u, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eq, input logic [31:0] er, input logic ed,
                       input int stall, input string tag);
    int lat;
    int el;
    el = exp_lat(u, av, bv);
    use_u = u;
    a = av;
    b = bv;
    if (u) iv_u = 1'b1; else iv_s = 1'b1;
    #1;
    check({tag, ":in_ready_idle"}, 32'(ir), 32'd1);
    check({tag, ":out_valid_idle"}, 32'(ov), 32'd0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv_s = 1'b0;
    iv_u = 1'b0;
    check({tag, ":in_ready_busy"}, 32'(ir), 32'd0);
    while (ov !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, ":latency"}, 32'(lat), 32'(el));
    check({tag, ":quo"}, quo_o, eq);
    check({tag, ":rem"}, rem_o, er);
    check({tag, ":dbz"}, 32'(dbz_o), 32'(ed));
    // Stall with out_ready low; also present a different operand that must be ignored.
    for (int i = 0; i < stall; i++) begin
      a = ~av;
      b = bv + 32'd1;
      if (u) iv_u = 1'b1; else iv_s = 1'b1;
      @(negedge clk);
      check({tag, ":stall_valid"}, 32'(ov), 32'd1);
      check({tag, ":stall_ready"}, 32'(ir), 32'd0);
      check({tag, ":stall_quo"}, quo_o, eq);
      check({tag, ":stall_rem"}, rem_o, er);
    end
    iv_s = 1'b0;
    iv_u = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":drain_valid"}, 32'(ov), 32'd0);
    check({tag, ":drain_ready"}, 32'(ir), 32'd1);
    check({tag, ":drain_dbz"}, 32'(dbz_o), 32'd0);
    $display("op %s a=%0h b=%0h quo=%0h rem=%0h lat=%0d", tag, av, bv, eq, er, lat);
  endtask

  initial begin
    // Reset values on both instances.
    repeat (2) @(negedge clk);
    check("rst:s_in_ready", 32'(ir_s), 32'd1);
    check("rst:s_out_valid", 32'(ov_s), 32'd0);
    check("rst:s_quo", quo_s, 32'd0);
    check("rst:s_rem", rem_s, 32'd0);
    check("rst:s_dbz", 32'(dbz_s), 32'd0);
    check("rst:u_in_ready", 32'(ir_u), 32'd1);
    check("rst:u_out_valid", 32'(ov_u), 32'd0);
    rst_n = 1'b1;

    do_op(1'b0, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0, 0, "s_7_2");
    do_op(1'b0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 0, "s_m7_2");
    do_op(1'b0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 0, "s_7_m2");
    do_op(1'b0, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 0, "s_m7_m2");
    do_op(1'b0, 32'd100,        32'd0,          32'd0,          32'd0,          1'b1, 0, "s_100_0");
    do_op(1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 0, "s_min_m1");
    do_op(1'b1, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF,   32'd15,         1'b0, 10, "u_max_16");
    do_op(1'b1, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 0, "u_fff9_2");

    // Reset mid-operation after 10 iterations: accept, PREP, then 10 ITER edges.
    use_u = 1'b0;
    a = 32'd1000;
    b = 32'd7;
    iv_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_s = 1'b0;
    repeat (11) @(negedge clk);
    check("abort:busy_valid", 32'(ov_s), 32'd0);
    check("abort:busy_ready", 32'(ir_s), 32'd0);
    rst_n = 1'b0;
    a = 32'd9;
    b = 32'd4;
    iv_s = 1'b1;
    #1;
    check("abort:in_reset_valid", 32'(ov_s), 32'd0);
    check("abort:in_reset_ready", 32'(ir_s), 32'd1);
    @(negedge clk);
    check("abort:reset_held_valid", 32'(ov_s), 32'd0);
    rst_n = 1'b1;
    do_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 0, "s_9_4_after_rst");

    do_op(1'b0, 32'd5,   32'd3, 32'd1, 32'd2, 1'b0, 0, "s_5_3");
    do_op(1'b0, 32'd0,   32'd5, 32'd0, 32'd0, 1'b0, 0, "s_0_5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
